// File: rtl/ka_pkg.sv
// ============================================================================
// ka_pkg : shared types and widths for the sequential Karatsuba multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ka_pkg;

  localparam int N  = 8;
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;
  localparam int OW = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ka_seq_mult_8bit_if.sv
// ============================================================================
// ka_seq_mult_8bit_if : operand/result valid-ready bus of the multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface ka_seq_mult_8bit_if;
  import ka_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] p;
  logic          busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

`default_nettype wire

// File: rtl/ka_seq_mult_8bit_clmul.sv
// ============================================================================
// clmul_4bit : combinational 4x4 carry-less multiplier, 7-bit product
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module clmul_4bit
  import ka_pkg::*;
(
  input  wire logic [H-1:0]  a,
  input  wire logic [H-1:0]  b,
  output logic      [PW-1:0] prod
);

  always_comb begin
    prod = '0;
    for (int i = 0; i < H; i++) begin
      if (b[i]) begin
        prod = prod ^ ({{(PW-H){1'b0}}, a} << i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/overlap_module_8bit.sv
// ============================================================================
// overlap_module_8bit : places three 7-bit Karatsuba terms at offsets 0/4/8
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module overlap_module_8bit (
  input  wire logic [6:0]  B2_in1,
  input  wire logic [6:0]  B2_in2,
  input  wire logic [6:0]  B2_in3,
  output logic      [14:0] B2_out
);

  assign B2_out = {8'b0, B2_in1} ^ {4'b0, B2_in2, 4'b0} ^ {B2_in3, 8'b0};

endmodule

`default_nettype wire

// File: rtl/ka_seq_mult_8bit.sv
// ============================================================================
// ka_seq_mult_8bit : sequential 8-bit Karatsuba carry-less multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ka_seq_mult_8bit #(
  parameter int N = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ka_seq_mult_8bit_if.slave bus
);
  import ka_pkg::*;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [PW-1:0] r_p0;
  logic [PW-1:0] r_p2;
  logic [PW-1:0] r_pm;
  logic [OW-1:0] r_p;

  logic          w_accept;
  logic [H-1:0]  w_mul_a;
  logic [H-1:0]  w_mul_b;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_pm;
  logic [PW-1:0] w_mid;
  logic [OW-1:0] w_result;

  // out_ready -> in_ready is combinational so DONE can hand off and accept in one edge
  assign bus.in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.p         = r_p;
  assign w_accept      = bus.in_valid && bus.in_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LO;
      LO:      w_next = HI;
      HI:      w_next = MID;
      MID:     w_next = DONE;
      DONE: begin
        if (w_accept)           w_next = LO;
        else if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      LO: begin
        w_mul_a = r_a[H-1:0];
        w_mul_b = r_b[H-1:0];
      end
      HI: begin
        w_mul_a = r_a[N-1:H];
        w_mul_b = r_b[N-1:H];
      end
      MID: begin
        w_mul_a = r_a[H-1:0] ^ r_a[N-1:H];
        w_mul_b = r_b[H-1:0] ^ r_b[N-1:H];
      end
      default: ;
    endcase
  end

  clmul_4bit u_clmul (
    .a    (w_mul_a),
    .b    (w_mul_b),
    .prod (w_prod)
  );

  // Pm is still being computed during MID, so the result uses the live product then
  assign w_pm  = (r_state == MID) ? w_prod : r_pm;
  assign w_mid = w_pm ^ r_p0 ^ r_p2;

  overlap_module_8bit u_overlap (
    .B2_in1 (r_p0),
    .B2_in2 (w_mid),
    .B2_in3 (r_p2),
    .B2_out (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p0    <= '0;
      r_p2    <= '0;
      r_pm    <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
      if (r_state == LO) r_p0 <= w_prod;
      if (r_state == HI) r_p2 <= w_prod;
      if (r_state == MID) begin
        r_pm <= w_prod;
        r_p  <= w_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ka_seq_mult_8bit.sv
// ============================================================================
// tb_ka_seq_mult_8bit : directed and random checks of ka_seq_mult_8bit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ka_seq_mult_8bit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ka_seq_mult_8bit_if bus ();

  ka_seq_mult_8bit #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] clmul_ref(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (y[i]) r = r ^ ({7'b0, x} << i);
    return r;
  endfunction

  // Drive one operand pair, return cycles from accept cycle to out_valid and the product.
  task automatic do_op(input logic [7:0] aa, input logic [7:0] bb, input logic ordy,
                       output int lat, output logic [14:0] pv, output bit ok);
    ok  = 1'b0;
    lat = 0;
    pv  = '0;
    @(negedge clk);
    bus.a = aa; bus.b = bb; bus.in_valid = 1'b1; bus.out_ready = ordy;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i; pv = bus.p; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.p !== 15'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b p=%h busy=%b, required 0 0 0000 0",
               bus.in_ready, bus.out_valid, bus.p, bus.busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", bus.in_ready);
    end
    // start an operation and abort it while in MID
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    vectors++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pre_mid: busy=%b out_valid=%b required 1 0", bus.busy, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.p !== 15'h0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: in_ready=%b out_valid=%b p=%h busy=%b, required 0 0 0000 0",
               bus.in_ready, bus.out_valid, bus.p, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.p !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_held: out_valid=%b p=%h required 0 0000", bus.out_valid, bus.p);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_after_release: in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_no_output: cycle %0d out_valid=%b busy=%b required 0 0", i, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic [14:0] pv; bit ok;
    do_op(8'h12, 8'h34, 1'b1, lat, pv, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout: out_valid never seen, required within 20 cycles");
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, required 4", lat);
    end
    vectors++;
    if (pv !== 15'h0328) begin
      miscompares++;
      $display("FAIL basic_product: p=%h required 0328", pv);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_handoff: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0]  ta [4] = '{8'hFF, 8'h80, 8'h03, 8'h00};
    logic [7:0]  tb [4] = '{8'hFF, 8'h80, 8'h03, 8'hA7};
    logic [14:0] tp [4] = '{15'h5555, 15'h4000, 15'h0005, 15'h0000};
    int lat; logic [14:0] pv; bit ok;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 1'b1, lat, pv, ok);
      vectors++;
      if (!ok || lat !== 4 || pv !== tp[i]) begin
        miscompares++;
        $display("FAIL corner_%0d: a=%h b=%h ok=%0d lat=%0d p=%h, required lat=4 p=%h",
                 i, ta[i], tb[i], ok, lat, pv, tp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [14:0] pv; bit ok;
    do_op(8'hFF, 8'hFF, 1'b0, lat, pv, ok);
    vectors++;
    if (!ok || pv !== 15'h5555) begin
      miscompares++;
      $display("FAIL bp_first: ok=%0d p=%h required 5555", ok, pv);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.in_valid = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.p !== 15'h5555 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b p=%h in_ready=%b, required 1 5555 0",
                 i, bus.out_valid, bus.p, bus.in_ready);
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: in_ready=%b out_valid=%b required 1 1", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: out_valid=%b busy=%b required 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  sa [3] = '{8'h12, 8'hFF, 8'h80};
    logic [7:0]  sb [3] = '{8'h34, 8'hFF, 8'h80};
    logic [14:0] sp [3] = '{15'h0328, 15'h5555, 15'h4000};
    int idx, nout, last;
    bit acc;
    idx = 0; nout = 0; last = 0;
    @(negedge clk);
    bus.a = sa[0]; bus.b = sb[0]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && nout < 3; c++) begin
      if (bus.out_valid) begin
        vectors++;
        if (bus.p !== sp[nout] || (c - last) !== 4) begin
          miscompares++;
          $display("FAIL b2b_result_%0d: p=%h gap=%0d, required p=%h gap=4", nout, bus.p, c - last, sp[nout]);
        end
        if (nout < 2) begin
          vectors++;
          if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_same_cycle_accept_%0d: in_ready=%b required 1", nout, bus.in_ready);
          end
        end
        last = c;
        nout++;
        if (nout == 3) break;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.a = sa[idx]; bus.b = sb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (nout !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, required 3", nout);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    localparam int NR = 10000;
    logic [14:0] q[$];
    logic [14:0] exp_p;
    int  sent, got;
    bit  acc;
    sent = 0; got = 0; acc = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 70000 && got < NR; cyc++) begin
      @(posedge clk);
      #1;
      if (!bus.in_valid || acc) begin
        if (sent < NR && $urandom_range(0, 7) != 0) begin
          bus.in_valid = 1'b1; bus.a = 8'($urandom); bus.b = 8'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL random_extra: unexpected result p=%h with nothing outstanding", bus.p);
        end else begin
          exp_p = q.pop_front();
          if (bus.p !== exp_p) begin
            miscompares++;
            $display("FAIL random_product_%0d: p=%h required %h", got, bus.p, exp_p);
          end
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        q.push_back(clmul_ref(bus.a, bus.b));
        sent++;
      end
    end
    vectors++;
    if (got !== NR || q.size() !== 0) begin
      miscompares++;
      $display("FAIL random_count: received %0d outstanding %0d, required %0d and 0", got, q.size(), NR);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
